cpu_bus_responder: RTL and testbench

- Target side of the CPU B multiplexed bus (6801-style: AS strobe, E strobe, RW, AD-low on P3, A-high on P4), the counterpart of the CPU bus write initiator.
- Decodes bus cycles into a configurable address window and holds a byte register file that the CPU can write and read back.
- Queues every accepted write as an {address, data} record in a small FIFO, for the test harness or downstream logic to drain via valid/ready.

---
 rtl/cpub_bus_pkg.sv | 25 ++
 rtl/cpub_rec_fifo.sv | 50 +++++
 rtl/cpu_bus_responder.sv | 172 +++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpub_bus_pkg.sv
// cpub_bus_pkg: shared bus-state enum, write-record type and window decode for the CPU B responder
package cpub_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } bus_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_rec_t;

  // 17-bit compare so a window ending at 16'hFFFF cannot wrap to address 0
  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base,
                                     input int unsigned aw);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, base};
    hi = lo + (17'd1 << aw) - 17'd1;
    return ({1'b0, addr} >= lo) && ({1'b0, addr} <= hi);
  endfunction

endpackage

// File: rtl/cpub_rec_fifo.sv
// cpub_rec_fifo: synchronous FIFO with combinational head, simultaneous push/pop when full, drop flag
module cpub_rec_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_drop
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_full;
  logic          w_pop;
  logic          w_wr;

  assign w_full  = r_count == (PW+1)'(DEPTH);
  assign o_valid = r_count != '0;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = o_valid & i_ready;
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr && !w_pop) r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_wr) r_count <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU B bus target with byte register file and write-record FIFO; CPUB_RESPONDER_TIMEOUT_EN adds a cycle watchdog
module cpu_bus_responder
  import cpub_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'h1000,
  parameter int          AW         = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 64
) (
  input  logic        XTAL_IN,
  input  logic        RESET_IN,
  input  logic        AS_IN,
  input  logic        E_IN,
  input  logic        RW_IN,
  input  logic [7:0]  P3_IN,
  input  logic [7:0]  P4_IN,
  output logic [7:0]  P3_OUT,
  output logic        P3_IOM,
  output logic        REC_VALID,
  input  logic        REC_READY,
  output logic [15:0] REC_ADDR,
  output logic [7:0]  REC_DATA,
  output logic        OVERFLOW,
  output logic        TIMEOUT_FLAG
);
  bus_state_t r_state;
  bus_state_t w_next;
  logic        r_as;
  logic        r_as_d;
  logic        r_e;
  logic        r_e_d;
  logic [15:0] r_addr;
  logic        r_rw;
  logic [7:0]  r_p3_out;
  logic        r_p3_iom;
  logic        r_overflow;
  logic [7:0]  r_regfile [2**AW];
  logic        w_as_rise;
  logic        w_e_rise;
  logic        w_e_fall;
  logic        w_in_win;
  logic        w_latch;
  logic        w_enter_data;
  logic        w_drive;
  logic        w_release;
  logic        w_push;
  logic        w_drop;
  logic        w_tmo;
  wr_rec_t     w_rec;
  wr_rec_t     w_head;

  assign w_as_rise = r_as & ~r_as_d;
  assign w_e_rise  = r_e & ~r_e_d;
  assign w_e_fall  = ~r_e & r_e_d;
  assign w_in_win  = in_window(r_addr, BASE_ADDR, AW);
  assign w_rec     = '{addr: r_addr, data: P3_IN};

`ifdef CPUB_RESPONDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_flag;

  assign w_tmo        = (r_state != ST_IDLE) && (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign TIMEOUT_FLAG = r_tmo_flag;

  // watchdog counts every cycle spent outside IDLE; flag is sticky until reset
  always_ff @(posedge XTAL_IN) begin
    if (!RESET_IN) begin
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
    end else begin
      r_tmo_cnt  <= (r_state == ST_IDLE || w_tmo) ? '0 : r_tmo_cnt + TW'(1);
      r_tmo_flag <= r_tmo_flag | w_tmo;
    end
  end
`else
  assign w_tmo        = 1'b0;
  assign TIMEOUT_FLAG = 1'b0;
`endif

  // sample strobes once and keep the previous sample for edge detection
  always_ff @(posedge XTAL_IN) begin
    if (!RESET_IN) begin
      r_as   <= 1'b0;
      r_as_d <= 1'b0;
      r_e    <= 1'b0;
      r_e_d  <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_as   <= AS_IN;
      r_as_d <= r_as;
      r_e    <= E_IN;
      r_e_d  <= r_e;
      r_state <= w_next;
    end
  end

  // next state plus one-cycle action strobes; a watchdog expiry overrides everything
  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_enter_data = 1'b0;
    w_release    = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_latch = w_as_rise;
        w_next  = w_as_rise ? ST_ADDR : ST_IDLE;
      end
      ST_ADDR: begin
        w_latch      = w_as_rise;
        w_enter_data = ~w_as_rise & w_e_rise;
        w_next       = w_enter_data ? ST_DATA : ST_ADDR;
      end
      ST_DATA: begin
        w_release = w_e_fall;
        w_push    = w_e_fall & ~r_rw & w_in_win;
        w_next    = w_e_fall ? ST_IDLE : ST_DATA;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_tmo) begin
      w_next       = ST_IDLE;
      w_latch      = 1'b0;
      w_enter_data = 1'b0;
      w_release    = 1'b1;
      w_push       = 1'b0;
    end
  end

  assign w_drive = w_enter_data & RW_IN & w_in_win;

  // address/direction capture, read-data drive and register file writes
  always_ff @(posedge XTAL_IN) begin
    if (!RESET_IN) begin
      r_addr     <= '0;
      r_rw       <= 1'b1;
      r_p3_out   <= '0;
      r_p3_iom   <= 1'b1;
      r_overflow <= 1'b0;
      for (int i = 0; i < 2**AW; i++) r_regfile[i] <= '0;
    end else begin
      if (w_latch) r_addr <= {P4_IN, P3_IN};
      if (w_enter_data) r_rw <= RW_IN;
      if (w_drive) r_p3_out <= r_regfile[r_addr[AW-1:0]];
      r_p3_iom <= w_drive ? 1'b0 : w_release ? 1'b1 : r_p3_iom;
      if (w_push) r_regfile[r_addr[AW-1:0]] <= P3_IN;
      r_overflow <= r_overflow | w_drop;
    end
  end

  cpub_rec_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    ($bits(wr_rec_t))
  ) u_fifo (
    .i_clk  (XTAL_IN),
    .i_rst_n(RESET_IN),
    .i_push (w_push),
    .i_data (w_rec),
    .i_ready(REC_READY),
    .o_valid(REC_VALID),
    .o_data (w_head),
    .o_drop (w_drop)
  );

  assign P3_OUT   = r_p3_out;
  assign P3_IOM   = r_p3_iom;
  assign REC_ADDR = w_head.addr;
  assign REC_DATA = w_head.data;
  assign OVERFLOW = r_overflow;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed bus cycles with hand-computed expectations for cpu_bus_responder
module tb_cpu_bus_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        as_in = 1'b0;
  logic        e_in = 1'b0;
  logic        rw_in = 1'b1;
  logic [7:0]  p3_in = '0;
  logic [7:0]  p4_in = '0;
  logic [7:0]  p3_out;
  logic        p3_iom;
  logic        rec_valid;
  logic        rec_ready = 1'b0;
  logic [15:0] rec_addr;
  logic [7:0]  rec_data;
  logic        overflow;
  logic        timeout_flag;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  cpu_bus_responder dut (
    .XTAL_IN     (clk),
    .RESET_IN    (rst_n),
    .AS_IN       (as_in),
    .E_IN        (e_in),
    .RW_IN       (rw_in),
    .P3_IN       (p3_in),
    .P4_IN       (p4_in),
    .P3_OUT      (p3_out),
    .P3_IOM      (p3_iom),
    .REC_VALID   (rec_valid),
    .REC_READY   (rec_ready),
    .REC_ADDR    (rec_addr),
    .REC_DATA    (rec_data),
    .OVERFLOW    (overflow),
    .TIMEOUT_FLAG(timeout_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic as_phase(input logic [15:0] a);
    {p4_in, p3_in} = a;
    as_in = 1'b1;
    tick(3);
    as_in = 1'b0;
    tick(2);
  endtask

  // full bus cycle; for reads, checks the drive state while E is high
  task automatic bus_cycle(input logic [15:0] a, input logic rd, input logic [7:0] d, input logic inwin);
    as_phase(a);
    rw_in = rd;
    p3_in = rd ? 8'h00 : d;
    e_in  = 1'b1;
    tick(4);
    if (rd) begin
      chk("rd_iom_e_high", {31'd0, p3_iom}, {31'd0, ~inwin});
      if (inwin) chk("rd_data", {24'd0, p3_out}, {24'd0, d});
    end
    e_in = 1'b0;
    tick(3);
    if (rd) chk("rd_iom_after", {31'd0, p3_iom}, 32'd1);
    p3_in = '0;
    rw_in = 1'b1;
    tick(1);
  endtask

  task automatic pop_one;
    rec_ready = 1'b1;
    tick(1);
    rec_ready = 1'b0;
  endtask

  initial begin
    tick(3);
    chk("rst_iom", {31'd0, p3_iom}, 32'd1);
    chk("rst_out", {24'd0, p3_out}, 32'd0);
    chk("rst_valid", {31'd0, rec_valid}, 32'd0);
    chk("rst_addr", {16'd0, rec_addr}, 32'd0);
    chk("rst_data", {24'd0, rec_data}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_flag}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    bus_cycle(16'h1003, 1'b0, 8'hA5, 1'b1);
    chk("wr_valid", {31'd0, rec_valid}, 32'd1);
    chk("wr_addr", {16'd0, rec_addr}, 32'h1003);
    chk("wr_data", {24'd0, rec_data}, 32'hA5);
    pop_one();
    chk("pop_empty", {31'd0, rec_valid}, 32'd0);
    bus_cycle(16'h1003, 1'b1, 8'hA5, 1'b1);
    bus_cycle(16'h1004, 1'b1, 8'h00, 1'b1);

    bus_cycle(16'h0FFF, 1'b0, 8'h11, 1'b0);
    chk("below_win", {31'd0, rec_valid}, 32'd0);
    bus_cycle(16'h1010, 1'b0, 8'h22, 1'b0);
    chk("above_win", {31'd0, rec_valid}, 32'd0);
    bus_cycle(16'h1010, 1'b1, 8'h00, 1'b0);
    bus_cycle(16'h0FFF, 1'b1, 8'h00, 1'b0);
    bus_cycle(16'h100F, 1'b0, 8'h5A, 1'b1);
    chk("top_valid", {31'd0, rec_valid}, 32'd1);
    chk("top_addr", {16'd0, rec_addr}, 32'h100F);
    chk("top_data", {24'd0, rec_data}, 32'h5A);
    pop_one();
    bus_cycle(16'h100F, 1'b1, 8'h5A, 1'b1);
    bus_cycle(16'h1000, 1'b1, 8'h00, 1'b1);

    for (int i = 0; i < 9; i++) bus_cycle(16'h1000 + 16'(i), 1'b0, 8'h10 + 8'(i), 1'b1);
    chk("full_ovf", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_valid%0d", i), {31'd0, rec_valid}, 32'd1);
      chk($sformatf("drain_addr%0d", i), {16'd0, rec_addr}, 32'h1000 + i);
      chk($sformatf("drain_data%0d", i), {24'd0, rec_data}, 32'h10 + i);
      pop_one();
    end
    chk("drain_empty", {31'd0, rec_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    bus_cycle(16'h1008, 1'b1, 8'h18, 1'b1);

    as_phase(16'h1005);
    rw_in = 1'b0;
    p3_in = 8'h77;
    e_in  = 1'b1;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_iom", {31'd0, p3_iom}, 32'd1);
    e_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    p3_in = '0;
    rw_in = 1'b1;
    chk("midrst_norec", {31'd0, rec_valid}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    bus_cycle(16'h1003, 1'b1, 8'h00, 1'b1);
    bus_cycle(16'h1005, 1'b1, 8'h00, 1'b1);
    bus_cycle(16'h1006, 1'b0, 8'h66, 1'b1);
    chk("post_valid", {31'd0, rec_valid}, 32'd1);
    chk("post_addr", {16'd0, rec_addr}, 32'h1006);
    chk("post_data", {24'd0, rec_data}, 32'h66);
    pop_one();

    as_phase(16'h1002);
    tick(70);
    rw_in = 1'b0;
    p3_in = 8'h3C;
    e_in  = 1'b1;
    tick(4);
    e_in = 1'b0;
    tick(3);
    p3_in = '0;
    rw_in = 1'b1;
`ifdef CPUB_RESPONDER_TIMEOUT_EN
    chk("tmo_flag", {31'd0, timeout_flag}, 32'd1);
    chk("tmo_norec", {31'd0, rec_valid}, 32'd0);
    chk("tmo_iom", {31'd0, p3_iom}, 32'd1);
    bus_cycle(16'h1002, 1'b1, 8'h00, 1'b1);
`else
    chk("notmo_flag", {31'd0, timeout_flag}, 32'd0);
    chk("notmo_valid", {31'd0, rec_valid}, 32'd1);
    chk("notmo_addr", {16'd0, rec_addr}, 32'h1002);
    chk("notmo_data", {24'd0, rec_data}, 32'h3C);
    pop_one();
    bus_cycle(16'h1002, 1'b1, 8'h3C, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
